// File: rtl/p09_pkg.sv
// Shared definitions for the SPI register controller: FSM encoding, opcodes
// and the layout of the 16-bit SPI header word.
package p09_pkg;

    localparam int HDR_W = 16;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP      = 4'h0,
        OP_WRITE    = 4'h1,
        OP_SNAPSHOT = 4'h2
    } opcode_t;

    // Header layout, MSB first: opcode [15:12], start address [11:8], count [7:0].
    typedef struct packed {
        logic [3:0]       opcode;
        logic [3:0]       addr;
        logic [CNT_W-1:0] count;
    } hdr_t;

    function automatic hdr_t decode_hdr(input logic [HDR_W-1:0] word);
        return hdr_t'(word);
    endfunction

endpackage

// File: rtl/p09_spi_reg_ctrl_if.sv
// Game-engine write request port and register-bank write port of the
// SPI register controller.
interface p09_spi_reg_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              game_wr_req;
    logic [ADDR_W-1:0] game_wr_addr;
    logic [DATA_W-1:0] game_wr_data;
    logic              game_wr_gnt;
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [DATA_W-1:0] reg_wr_data;

    modport master (
        output game_wr_req, game_wr_addr, game_wr_data,
        input  game_wr_gnt, reg_wr_en, reg_wr_addr, reg_wr_data
    );

    modport slave (
        input  game_wr_req, game_wr_addr, game_wr_data,
        output game_wr_gnt, reg_wr_en, reg_wr_addr, reg_wr_data
    );
endinterface

// File: rtl/p09_wr_arb.sv
// Register-bank write arbiter: SPI writes win over game writes, and the chosen
// write is registered so it reaches the bank exactly one clock after acceptance.
module p09_wr_arb #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_wr,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_data,
    input  logic              game_req,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_data,
    output logic              game_gnt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    logic              en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    assign game_gnt = game_req && !spi_wr && !rst;

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (spi_wr) begin
            en_q   <= 1'b1;
            addr_q <= spi_addr;
            data_q <= spi_data;
        end else if (game_gnt) begin
            en_q   <= 1'b1;
            addr_q <= game_addr;
            data_q <= game_data;
        end else begin
            en_q   <= 1'b0;
        end
    end

    // A write queued just before reset must never reach the bank.
    assign wr_en   = en_q && !rst;
    assign wr_addr = rst ? '0 : addr_q;
    assign wr_data = rst ? '0 : data_q;

endmodule

// File: rtl/p09_spi_reg_ctrl.sv
// SPI-driven register controller: decodes a header word, streams data words
// into the register bank and shares the write port with the game engine.
module p09_spi_reg_ctrl
    import p09_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_start,
    input  logic              spi_active,
    input  logic [DATA_W-1:0] spi_word,
    input  logic              spi_word_valid,
    p09_spi_reg_ctrl_if.slave bus,
    output logic              snapshot,
    output logic              busy,
    output logic              err
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  count_q;
    logic              snapshot_q;
    logic              err_q;
    hdr_t              hdr;
    logic              spi_wr;

    assign hdr    = decode_hdr(spi_word[HDR_W-1:0]);
    assign spi_wr = (state == ST_DATA) && spi_word_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            snapshot_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            snapshot_q <= 1'b0;
            if (spi_start) begin
                state   <= ST_HDR;
                count_q <= '0;
            end else if (state != ST_IDLE && !spi_active) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_HDR: if (spi_word_valid) begin
                        addr_q  <= ADDR_W'(hdr.addr);
                        count_q <= hdr.count;
                        case (hdr.opcode)
                            OP_NOP:   state <= ST_DRAIN;
                            OP_WRITE: state <= (hdr.count == '0) ? ST_DRAIN : ST_DATA;
                            OP_SNAPSHOT: begin
                                snapshot_q <= 1'b1;
                                state      <= ST_DRAIN;
                            end
                            default: begin
                                err_q <= 1'b1;
                                state <= ST_DRAIN;
                            end
                        endcase
                    end
                    ST_DATA: if (spi_word_valid) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        count_q <= count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) state <= ST_DRAIN;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Flags are forced low while rst is held, not only after the reset edge.
    assign busy     = (state != ST_IDLE) && !rst;
    assign snapshot = snapshot_q && !rst;
    assign err      = err_q && !rst;

    p09_wr_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .spi_wr    (spi_wr),
        .spi_addr  (addr_q),
        .spi_data  (spi_word),
        .game_req  (bus.game_wr_req),
        .game_addr (bus.game_wr_addr),
        .game_data (bus.game_wr_data),
        .game_gnt  (bus.game_wr_gnt),
        .wr_en     (bus.reg_wr_en),
        .wr_addr   (bus.reg_wr_addr),
        .wr_data   (bus.reg_wr_data)
    );

endmodule

// File: tb/tb_p09_spi_reg_ctrl.sv
// Scoreboard bench for p09_spi_reg_ctrl: stimulus pushes expected writes and
// flags from a transaction-level model; a negedge monitor pops and compares.
module tb_p09_spi_reg_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_start;
    logic              spi_active;
    logic [DATA_W-1:0] spi_word;
    logic              spi_word_valid;
    logic              snapshot;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    p09_spi_reg_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    p09_spi_reg_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_start      (spi_start),
        .spi_active     (spi_active),
        .spi_word       (spi_word),
        .spi_word_valid (spi_word_valid),
        .bus            (bus),
        .snapshot       (snapshot),
        .busy           (busy),
        .err            (err)
    );

    typedef struct {
        int addr;
        int data;
        int due;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;

    // Transaction-level model of the SPI side.
    bit m_in_txn, m_hdr_done, m_snap_pend, m_err;
    int m_left, m_addr;

    bit game_auto, game_pend;
    int game_addr, game_data;

    bit exp_gnt, exp_busy, exp_snap, exp_err;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus plus the model's prediction for that clock.
    task automatic tick(input bit r, input bit st, input bit act, input bit v, input int w);
        bit spi_wr;
        int op;
        @(posedge clk);
        #1;
        if (game_auto && !game_pend && $urandom_range(0, 1) == 1) begin
            game_pend = 1'b1;
            game_addr = $urandom_range(0, 15);
            game_data = $urandom_range(0, 65535);
        end
        rst               = r;
        spi_start         = st;
        spi_active        = act;
        spi_word_valid    = v;
        spi_word          = w[15:0];
        bus.game_wr_req   = game_pend;
        bus.game_wr_addr  = game_addr[3:0];
        bus.game_wr_data  = game_data[15:0];

        exp_busy = !r && m_in_txn;
        exp_snap = !r && m_snap_pend;
        exp_err  = !r && m_err;

        if (r) begin
            exp_gnt = 1'b0;
            while (exp_q.size() > 0 && exp_q[$].due == cyc) void'(exp_q.pop_back());
            m_in_txn = 0; m_hdr_done = 0; m_snap_pend = 0; m_err = 0;
            m_left = 0;   m_addr = 0;
        end else begin
            spi_wr = m_in_txn && m_hdr_done && m_left > 0 && v;
            if (spi_wr) begin
                exp_q.push_back('{addr: m_addr, data: w & 16'hFFFF, due: cyc + 1});
                m_addr = (m_addr + 1) % 16;
                m_left--;
            end
            exp_gnt = game_pend && !spi_wr;
            if (exp_gnt) begin
                exp_q.push_back('{addr: game_addr, data: game_data, due: cyc + 1});
                game_pend = 1'b0;
            end
            m_snap_pend = 1'b0;
            if (st) begin
                m_in_txn = 1; m_hdr_done = 0; m_left = 0;
            end else if (m_in_txn && !act) begin
                m_in_txn = 0; m_left = 0;
            end else if (m_in_txn && !m_hdr_done && v) begin
                m_hdr_done = 1;
                op = (w >> 12) & 15;
                m_left = 0;
                if (op == 1) begin
                    m_left = w & 255;
                    m_addr = (w >> 8) & 15;
                end else if (op == 2) begin
                    m_snap_pend = 1'b1;
                end else if (op != 0) begin
                    m_err = 1'b1;
                end
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n, input bit act);
        repeat (n) tick(0, 0, act, 0, $urandom_range(0, 65535));
    endtask

    task automatic open_txn();
        tick(0, 1, 1, 0, 0);
        idle(3, 1);
    endtask

    // Words arrive no more often than once per 16 clocks.
    task automatic send(input int w);
        tick(0, 0, 1, 1, w);
        idle(15, 1);
    endtask

    task automatic close_txn();
        idle(3, 0);
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        bit  want;
        if (mon_en) begin
            check("game_wr_gnt", bus.game_wr_gnt, exp_gnt);
            check("busy", busy, exp_busy);
            check("snapshot", snapshot, exp_snap);
            check("err", err, exp_err);
            want = exp_q.size() > 0 && exp_q[0].due == cyc;
            check("reg_wr_en", bus.reg_wr_en, want);
            if (want) begin
                e = exp_q.pop_front();
                if (bus.reg_wr_en) begin
                    check("reg_wr_addr", bus.reg_wr_addr, e.addr);
                    check("reg_wr_data", bus.reg_wr_data, e.data);
                end
            end
        end
    end

    initial begin
        int op, cnt, nw, stop_at, hdr;
        rst = 1'b1; spi_start = 1'b0; spi_active = 1'b0;
        spi_word_valid = 1'b0; spi_word = '0;
        bus.game_wr_req = 1'b0; bus.game_wr_addr = '0; bus.game_wr_data = '0;
        game_auto = 1'b0; game_pend = 1'b0;

        repeat (3) tick(1, 0, 0, 0, 0);
        idle(4, 0);

        // Five-word burst from addr 3, then an ignored sixth word.
        open_txn();
        send(16'h1305);
        repeat (6) send($urandom_range(0, 65535));
        close_txn();

        // Address wrap 14, 15, 0.
        open_txn();
        send(16'h1E03);
        repeat (3) send($urandom_range(0, 65535));
        close_txn();

        // Snapshot header.
        open_txn();
        send(16'h2000);
        send(16'h1234);
        close_txn();

        // Bad opcode; err must survive the following write transaction.
        open_txn();
        send(16'h7000);
        send(16'hBEEF);
        close_txn();
        open_txn();
        send(16'h1A02);
        repeat (2) send($urandom_range(0, 65535));
        close_txn();

        // Game engine requesting continuously through a write burst.
        game_auto = 1'b1;
        open_txn();
        send(16'h1004);
        repeat (4) send($urandom_range(0, 65535));
        close_txn();
        game_auto = 1'b0;
        idle(4, 0);

        // Abort after 2 of 4 words, then reset in the middle of a new burst.
        open_txn();
        send(16'h1104);
        repeat (2) send($urandom_range(0, 65535));
        close_txn();
        open_txn();
        send(16'h1802);
        tick(0, 0, 1, 1, $urandom_range(0, 65535));
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 0);
        idle(4, 1);
        send($urandom_range(0, 65535));
        close_txn();

        // Randomised transactions, restarts, aborts and resets.
        game_auto = 1'b1;
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 5))
                0:       op = 0;
                1, 2, 3: op = 1;
                4:       op = 2;
                default: op = $urandom_range(3, 15);
            endcase
            cnt = $urandom_range(0, 6);
            hdr = (op << 12) | ($urandom_range(0, 15) << 8) | cnt;
            open_txn();
            send(hdr);
            nw = cnt + $urandom_range(0, 2);
            stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nw) : nw;
            for (int i = 0; i < nw && i < stop_at; i++) send($urandom_range(0, 65535));
            if ($urandom_range(0, 4) != 0) close_txn();
            if ($urandom_range(0, 7) == 0) begin
                tick(1, 0, 0, 0, 0);
                idle(2, 0);
            end
        end
        game_auto = 1'b0;
        idle(6, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/p09_spi_reg_ctrl.md
P09_SPI_REG_CTRL -- requirements
Module: p09_spi_reg_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, register-bank address width.
REQ-002 Parameter DATA_W, default 16, register and SPI word width.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 spi_start  input  1  one-clk pulse, SPI slave-select falling edge detected.
REQ-006 spi_active  input  1  high while an SPI transaction is open.
REQ-007 spi_word  input  DATA_W  last complete received word.
REQ-008 spi_word_valid  input  1  one-clk pulse, spi_word complete; at most one per 16 clk.
REQ-009 game_wr_req  input  1  game-engine write request, held until granted.
REQ-010 game_wr_addr  input  ADDR_W  game write address.
REQ-011 game_wr_data  input  DATA_W  game write data.
REQ-012 game_wr_gnt  output  1  combinational grant for game_wr_req.
REQ-013 reg_wr_en  output  1  registered register-bank write strobe.
REQ-014 reg_wr_addr  output  ADDR_W  registered write address.
REQ-015 reg_wr_data  output  DATA_W  registered write data.
REQ-016 snapshot  output  1  one-clk pulse, game state copied into the SPI shift-out state.
REQ-017 busy  output  1  high whenever FSM not IDLE.
REQ-018 err  output  1  sticky bad-opcode flag.

Function
REQ-019 FSM states SHALL be IDLE, HDR, DATA, DRAIN.
REQ-020 IDLE->HDR on spi_start; spi_start in any other state SHALL also go to HDR (restart), discarding the remaining count.
REQ-021 HDR on spi_word_valid decodes spi_word: [15:12] opcode, [11:8] start addr (low ADDR_W bits used), [7:0] count.
REQ-022 Opcode 0x0 NOP -> DRAIN; 0x1 WRITE -> DATA, or DRAIN if count==0; 0x2 SNAPSHOT -> snapshot pulse next cycle, then DRAIN; any other -> err set, DRAIN.
REQ-023 DATA: each spi_word_valid SHALL queue one SPI write at the current addr; addr increments modulo 2^ADDR_W (wrap 15->0); count decrements; count reaching 0 -> DRAIN.
REQ-024 DRAIN SHALL ignore spi_word_valid.
REQ-025 spi_active low in HDR, DATA or DRAIN SHALL go to IDLE (abort); a write queued in that same cycle SHALL still be issued.
REQ-026 Write port latency: reg_wr_* asserted exactly one clk after the accepting spi_word_valid cycle or game_wr_gnt cycle.
REQ-027 Arbitration: SPI has priority; game_wr_gnt = game_wr_req and not (state==DATA and spi_word_valid).
REQ-028 A game request SHALL wait at most 1 clk.
REQ-029 reg_wr_en SHALL be a single-cycle pulse per accepted write; no write is ever dropped or duplicated.
REQ-030 err SHALL clear only on rst.

Reset
REQ-031 On rst: state IDLE; reg_wr_en, reg_wr_addr, reg_wr_data, snapshot, err, internal addr and count all 0.
REQ-032 rst mid-transaction SHALL cancel any queued write; the FSM waits in IDLE for the next spi_start.
REQ-033 Outputs SHALL be 0 during the rst cycle and the cycle after it; game_wr_gnt SHALL be 0 while rst is high.

Structure
REQ-034 Opcode constants, header field positions and FSM state encoding SHALL live in a shared package (p09_pkg).
REQ-035 The arbiter plus the output register SHALL be one sub-module, p09_wr_arb; the FSM stays in the top.

Verification
REQ-036 Header 0x1305 followed by 5 data words -> writes to addr 3,4,5,6,7, each 1 clk after its word, then DRAIN; a 6th word is ignored.
REQ-037 Header 0x1E03 -> writes to addr 14,15,0 (wrap).
REQ-038 Header 0x2000 -> a single snapshot pulse 1 clk after the header; no reg_wr_en.
REQ-039 Header 0x7000 -> err=1, no writes; err stays 1 across the next transaction until rst.
REQ-040 game_wr_req held high during a WRITE burst -> gnt low only in word_valid cycles; game writes appear between SPI writes, none lost.
REQ-041 spi_active dropped after 2 of 4 words, then rst asserted mid-burst on a new transaction -> exactly 2 writes for the first transaction, FSM IDLE, all outputs 0.
